// File: rtl/tt_cam_buffer_alloc_ctrl_if.sv
// Port bundle between the CAM buffer allocation controller and its producer,
// response source, retire consumer and the tag+data buffer it manages.
interface tt_cam_buffer_alloc_ctrl_if #(
    parameter int ENTRIES      = 8,
    parameter int ENTRIES_LOG2 = $clog2(ENTRIES),
    parameter int TAG_WIDTH    = 32,
    parameter int DATA_WIDTH   = 32
);
    logic                         i_alloc_valid;
    logic                         o_alloc_ready;
    logic [TAG_WIDTH-1:0]         i_alloc_tag;
    logic [ENTRIES_LOG2-1:0]      o_alloc_id;

    logic                         i_fill_valid;
    logic [ENTRIES_LOG2-1:0]      i_fill_id;
    logic [DATA_WIDTH-1:0]        i_fill_data;
    logic                         o_fill_err;

    logic                         o_retire_valid;
    logic                         i_retire_ready;
    logic [ENTRIES_LOG2-1:0]      o_retire_id;
    logic [TAG_WIDTH-1:0]         o_retire_tag;
    logic [DATA_WIDTH-1:0]        o_retire_data;

    logic                         i_flush;
    logic [ENTRIES_LOG2:0]        o_count;
    logic                         o_empty;
    logic                         o_full;

    logic                         o_buf_write_tag_en;
    logic [ENTRIES_LOG2-1:0]      o_buf_write_tag_addr;
    logic [TAG_WIDTH-1:0]         o_buf_write_tag_value;
    logic                         o_buf_write_data_en;
    logic [ENTRIES_LOG2-1:0]      o_buf_write_data_addr;
    logic [DATA_WIDTH-1:0]        o_buf_write_data_value;
    logic [ENTRIES-1:0]           o_buf_set_tag_valid;
    logic [ENTRIES-1:0]           o_buf_clear_tag_valid;
    logic [ENTRIES-1:0]           o_buf_set_data_valid;
    logic [ENTRIES-1:0]           o_buf_clear_data_valid;
    logic                         o_buf_read_en;
    logic [ENTRIES_LOG2-1:0]      o_buf_read_addr;
    logic [TAG_WIDTH+DATA_WIDTH-1:0] i_buf_read_value;
    logic [ENTRIES-1:0]           i_buf_data_valid;

    modport master (
        input  i_alloc_valid, i_alloc_tag, i_fill_valid, i_fill_id, i_fill_data,
               i_retire_ready, i_flush, i_buf_read_value, i_buf_data_valid,
        output o_alloc_ready, o_alloc_id, o_fill_err, o_retire_valid, o_retire_id,
               o_retire_tag, o_retire_data, o_count, o_empty, o_full,
               o_buf_write_tag_en, o_buf_write_tag_addr, o_buf_write_tag_value,
               o_buf_write_data_en, o_buf_write_data_addr, o_buf_write_data_value,
               o_buf_set_tag_valid, o_buf_clear_tag_valid, o_buf_set_data_valid,
               o_buf_clear_data_valid, o_buf_read_en, o_buf_read_addr
    );

    modport slave (
        output i_alloc_valid, i_alloc_tag, i_fill_valid, i_fill_id, i_fill_data,
               i_retire_ready, i_flush, i_buf_read_value, i_buf_data_valid,
        input  o_alloc_ready, o_alloc_id, o_fill_err, o_retire_valid, o_retire_id,
               o_retire_tag, o_retire_data, o_count, o_empty, o_full,
               o_buf_write_tag_en, o_buf_write_tag_addr, o_buf_write_tag_value,
               o_buf_write_data_en, o_buf_write_data_addr, o_buf_write_data_value,
               o_buf_set_tag_valid, o_buf_clear_tag_valid, o_buf_set_data_valid,
               o_buf_clear_data_valid, o_buf_read_en, o_buf_read_addr
    );
endinterface

// File: rtl/tt_cam_buffer_alloc_ctrl.sv
// In-order allocate / out-of-order fill / in-order retire controller for one
// tag+data CAM buffer, with a registered valid/ready retire stage.
module tt_cam_buffer_alloc_ctrl #(
    parameter int ENTRIES      = 8,
    parameter int ENTRIES_LOG2 = $clog2(ENTRIES),
    parameter int TAG_WIDTH    = 32,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    tt_cam_buffer_alloc_ctrl_if.master bus
);
    localparam int CW = ENTRIES_LOG2 + 1;
    localparam logic [CW-1:0]      FULL_COUNT = CW'(ENTRIES);
    localparam logic [ENTRIES-1:0] ONE_HOT0   = ENTRIES'(1);
    localparam logic [ENTRIES-1:0] ALL_ONES   = '1;

    logic [ENTRIES_LOG2-1:0] head, tail;
    logic [CW-1:0]           count;
    logic [ENTRIES-1:0]      alloc_vec;
    logic                    retire_valid;
    logic [ENTRIES_LOG2-1:0] retire_id;
    logic [TAG_WIDTH-1:0]    retire_tag;
    logic [DATA_WIDTH-1:0]   retire_data;
    logic                    fill_err;

    logic empty, full, alloc_ready, alloc_accept, load, fill_legal, fill_bad;
    logic [ENTRIES-1:0] tail_vec, head_vec, fill_vec;

    assign empty        = (count == '0);
    assign full         = (count == FULL_COUNT);
    assign alloc_ready  = !full && !bus.i_flush;
    assign alloc_accept = bus.i_alloc_valid && alloc_ready;
    assign load         = !empty && bus.i_buf_data_valid[head]
                          && (!retire_valid || bus.i_retire_ready) && !bus.i_flush;

    // The entry being allocated this cycle has no alloc_vec bit yet, so a
    // same-cycle fill to it is rejected; the explicit compare keeps that obvious.
    assign fill_legal = bus.i_fill_valid && !bus.i_flush
                        && alloc_vec[bus.i_fill_id]
                        && !bus.i_buf_data_valid[bus.i_fill_id]
                        && !(alloc_accept && (bus.i_fill_id == tail));
    assign fill_bad   = bus.i_fill_valid && !bus.i_flush && !fill_legal;

    assign tail_vec = alloc_accept ? (ONE_HOT0 << tail) : '0;
    assign head_vec = load ? (ONE_HOT0 << head) : '0;
    assign fill_vec = fill_legal ? (ONE_HOT0 << bus.i_fill_id) : '0;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            alloc_vec    <= '0;
            retire_valid <= 1'b0;
            retire_id    <= '0;
            retire_tag   <= '0;
            retire_data  <= '0;
            fill_err     <= 1'b0;
        end else if (bus.i_flush) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            alloc_vec    <= '0;
            retire_valid <= 1'b0;
            fill_err     <= 1'b0;
        end else begin
            fill_err  <= fill_bad;
            count     <= count + CW'(alloc_accept) - CW'(load);
            alloc_vec <= (alloc_vec | tail_vec) & ~head_vec;
            if (alloc_accept) tail <= tail + ENTRIES_LOG2'(1);
            if (load) begin
                head         <= head + ENTRIES_LOG2'(1);
                retire_valid <= 1'b1;
                retire_id    <= head;
                retire_tag   <= bus.i_buf_read_value[TAG_WIDTH+DATA_WIDTH-1 -: TAG_WIDTH];
                retire_data  <= bus.i_buf_read_value[DATA_WIDTH-1:0];
            end else if (retire_valid && bus.i_retire_ready) begin
                retire_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.o_buf_write_tag_en     = alloc_accept;
        bus.o_buf_write_tag_addr   = tail;
        bus.o_buf_write_tag_value  = bus.i_alloc_tag;
        bus.o_buf_write_data_en    = fill_legal;
        bus.o_buf_write_data_addr  = bus.i_fill_id;
        bus.o_buf_write_data_value = bus.i_fill_data;
        bus.o_buf_set_tag_valid    = tail_vec;
        bus.o_buf_set_data_valid   = fill_vec;
        bus.o_buf_clear_tag_valid  = head_vec;
        bus.o_buf_clear_data_valid = head_vec | tail_vec;
        // Flush wipes every valid bit; the buffer resolves clear over set.
        if (bus.i_flush) begin
            bus.o_buf_clear_tag_valid  = ALL_ONES;
            bus.o_buf_clear_data_valid = ALL_ONES;
        end
    end

    assign bus.o_alloc_ready   = alloc_ready;
    assign bus.o_alloc_id      = tail;
    assign bus.o_fill_err      = fill_err;
    assign bus.o_retire_valid  = retire_valid;
    assign bus.o_retire_id     = retire_id;
    assign bus.o_retire_tag    = retire_tag;
    assign bus.o_retire_data   = retire_data;
    assign bus.o_count         = count;
    assign bus.o_empty         = empty;
    assign bus.o_full          = full;
    assign bus.o_buf_read_en   = !empty;
    assign bus.o_buf_read_addr = head;
endmodule

// File: tb/tb_tt_cam_buffer_alloc_ctrl.sv
// Directed bench for tt_cam_buffer_alloc_ctrl with a behavioural tag+data
// buffer (clear-dominant valid bits, combinational read) hooked to its ports.
module tb_tt_cam_buffer_alloc_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    tt_cam_buffer_alloc_ctrl_if #(.ENTRIES(8), .TAG_WIDTH(32), .DATA_WIDTH(32)) bus ();

    tt_cam_buffer_alloc_ctrl #(.ENTRIES(8), .TAG_WIDTH(32), .DATA_WIDTH(32)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus.master)
    );

    logic [31:0] tag_mem  [8];
    logic [31:0] data_mem [8];
    logic [7:0]  tag_v, data_v;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_v  <= '0;
            data_v <= '0;
        end else begin
            tag_v  <= (tag_v | bus.o_buf_set_tag_valid) & ~bus.o_buf_clear_tag_valid;
            data_v <= (data_v | bus.o_buf_set_data_valid) & ~bus.o_buf_clear_data_valid;
            if (bus.o_buf_write_tag_en)  tag_mem[bus.o_buf_write_tag_addr]   <= bus.o_buf_write_tag_value;
            if (bus.o_buf_write_data_en) data_mem[bus.o_buf_write_data_addr] <= bus.o_buf_write_data_value;
        end
    end

    assign bus.i_buf_data_valid = data_v;
    assign bus.i_buf_read_value = {tag_mem[bus.o_buf_read_addr], data_mem[bus.o_buf_read_addr]};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_fill(input logic [2:0] id, input logic [31:0] data);
        bus.i_fill_valid = 1'b1;
        bus.i_fill_id    = id;
        bus.i_fill_data  = data;
    endtask

    task automatic do_reset();
        bus.i_alloc_valid  = 1'b0;
        bus.i_alloc_tag    = '0;
        bus.i_fill_valid   = 1'b0;
        bus.i_fill_id      = '0;
        bus.i_fill_data    = '0;
        bus.i_retire_ready = 1'b0;
        bus.i_flush        = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.o_alloc_ready !== 1'b1) begin bad++; $display("FAIL reset_alloc_ready got=%0b want=1", bus.o_alloc_ready); end
        total++; if (bus.o_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0b want=1", bus.o_empty); end
        total++; if (bus.o_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0b want=0", bus.o_full); end
        total++; if (bus.o_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.o_count); end
        total++; if (bus.o_retire_valid !== 1'b0) begin bad++; $display("FAIL reset_retire_valid got=%0b want=0", bus.o_retire_valid); end
        total++; if (bus.o_fill_err !== 1'b0) begin bad++; $display("FAIL reset_fill_err got=%0b want=0", bus.o_fill_err); end
        total++; if ({bus.o_buf_set_tag_valid, bus.o_buf_clear_tag_valid, bus.o_buf_set_data_valid, bus.o_buf_clear_data_valid} !== 32'h0)
            begin bad++; $display("FAIL reset_vectors got=%08h want=0", {bus.o_buf_set_tag_valid, bus.o_buf_clear_tag_valid, bus.o_buf_set_data_valid, bus.o_buf_clear_data_valid}); end
        total++; if ({bus.o_buf_write_tag_en, bus.o_buf_write_data_en, bus.o_buf_read_en} !== 3'b000)
            begin bad++; $display("FAIL reset_enables got=%03b want=000", {bus.o_buf_write_tag_en, bus.o_buf_write_data_en, bus.o_buf_read_en}); end
    endtask

    task automatic test_alloc_full();
        logic [7:0] exp_vec;
        for (int i = 0; i < 8; i++) begin
            bus.i_alloc_valid = 1'b1;
            bus.i_alloc_tag   = 32'h10 + 32'(i);
            exp_vec = 8'h01 << i;
            #1;
            total++; if (bus.o_alloc_ready !== 1'b1) begin bad++; $display("FAIL alloc_ready[%0d] got=%0b want=1", i, bus.o_alloc_ready); end
            total++; if (bus.o_alloc_id !== 3'(i)) begin bad++; $display("FAIL alloc_id[%0d] got=%0d want=%0d", i, bus.o_alloc_id, i); end
            total++; if (bus.o_buf_set_tag_valid !== exp_vec) begin bad++; $display("FAIL alloc_set_tag_valid[%0d] got=%02h want=%02h", i, bus.o_buf_set_tag_valid, exp_vec); end
            total++; if (bus.o_buf_write_tag_value !== 32'h10 + 32'(i)) begin bad++; $display("FAIL alloc_tag_value[%0d] got=%08h want=%08h", i, bus.o_buf_write_tag_value, 32'h10 + 32'(i)); end
            step();
        end
        #1;
        total++; if (bus.o_full !== 1'b1) begin bad++; $display("FAIL full_after_8 got=%0b want=1", bus.o_full); end
        total++; if (bus.o_count !== 4'd8) begin bad++; $display("FAIL count_after_8 got=%0d want=8", bus.o_count); end
        total++; if (bus.o_alloc_ready !== 1'b0) begin bad++; $display("FAIL ninth_alloc_ready got=%0b want=0", bus.o_alloc_ready); end
        total++; if (bus.o_buf_write_tag_en !== 1'b0) begin bad++; $display("FAIL ninth_tag_en got=%0b want=0", bus.o_buf_write_tag_en); end
        total++; if (bus.o_alloc_id !== 3'd0) begin bad++; $display("FAIL tail_wrap got=%0d want=0", bus.o_alloc_id); end
        step();
        bus.i_alloc_valid = 1'b0;
        #1;
        total++; if (bus.o_count !== 4'd8) begin bad++; $display("FAIL ninth_not_taken got=%0d want=8", bus.o_count); end
    endtask

    task automatic test_fill_order();
        bus.i_retire_ready = 1'b1;
        drive_fill(3'd3, 32'hA3);
        #1;
        total++; if (bus.o_buf_set_data_valid !== 8'h08) begin bad++; $display("FAIL fill3_set_dv got=%02h want=08", bus.o_buf_set_data_valid); end
        total++; if (bus.o_buf_write_data_en !== 1'b1 || bus.o_buf_write_data_addr !== 3'd3)
            begin bad++; $display("FAIL fill3_write got=%0b/%0d want=1/3", bus.o_buf_write_data_en, bus.o_buf_write_data_addr); end
        step();
        drive_fill(3'd0, 32'hA0);
        #1;
        total++; if (bus.o_retire_valid !== 1'b0) begin bad++; $display("FAIL early_retire_a got=%0b want=0", bus.o_retire_valid); end
        step();
        drive_fill(3'd1, 32'hA1);
        #1;
        total++; if (bus.o_retire_valid !== 1'b0) begin bad++; $display("FAIL early_retire_b got=%0b want=0", bus.o_retire_valid); end
        step();
        for (int k = 0; k < 4; k++) begin
            if (k == 0) drive_fill(3'd2, 32'hA2);
            else        bus.i_fill_valid = 1'b0;
            #1;
            total++; if (bus.o_retire_valid !== 1'b1) begin bad++; $display("FAIL retire_valid[%0d] got=%0b want=1", k, bus.o_retire_valid); end
            total++; if (bus.o_retire_id !== 3'(k)) begin bad++; $display("FAIL retire_id[%0d] got=%0d want=%0d", k, bus.o_retire_id, k); end
            total++; if (bus.o_retire_tag !== 32'h10 + 32'(k)) begin bad++; $display("FAIL retire_tag[%0d] got=%08h want=%08h", k, bus.o_retire_tag, 32'h10 + 32'(k)); end
            total++; if (bus.o_retire_data !== 32'hA0 + 32'(k)) begin bad++; $display("FAIL retire_data[%0d] got=%08h want=%08h", k, bus.o_retire_data, 32'hA0 + 32'(k)); end
            step();
        end
        #1;
        total++; if (bus.o_retire_valid !== 1'b0) begin bad++; $display("FAIL retire_drained got=%0b want=0", bus.o_retire_valid); end
        total++; if (bus.o_count !== 4'd4) begin bad++; $display("FAIL count_after_retire got=%0d want=4", bus.o_count); end
    endtask

    task automatic test_retire_stall();
        bus.i_retire_ready = 1'b0;
        drive_fill(3'd4, 32'hB4);
        step();
        drive_fill(3'd5, 32'hB5);
        #1;
        total++; if (bus.o_retire_valid !== 1'b0) begin bad++; $display("FAIL stall_pre got=%0b want=0", bus.o_retire_valid); end
        step();
        bus.i_fill_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            total++; if (bus.o_retire_valid !== 1'b1 || bus.o_retire_id !== 3'd4 || bus.o_retire_data !== 32'hB4 || bus.o_retire_tag !== 32'h14)
                begin bad++; $display("FAIL stall_hold[%0d] got=%0b/%0d/%08h/%08h want=1/4/b4/14", c, bus.o_retire_valid, bus.o_retire_id, bus.o_retire_data, bus.o_retire_tag); end
            total++; if (bus.o_count !== 4'd3) begin bad++; $display("FAIL stall_count[%0d] got=%0d want=3", c, bus.o_count); end
            step();
        end
        bus.i_retire_ready = 1'b1;
        #1;
        total++; if (bus.o_retire_id !== 3'd4) begin bad++; $display("FAIL release_first got=%0d want=4", bus.o_retire_id); end
        step();
        #1;
        total++; if (bus.o_retire_valid !== 1'b1 || bus.o_retire_id !== 3'd5 || bus.o_retire_data !== 32'hB5)
            begin bad++; $display("FAIL release_second got=%0b/%0d/%08h want=1/5/b5", bus.o_retire_valid, bus.o_retire_id, bus.o_retire_data); end
        total++; if (bus.o_count !== 4'd2) begin bad++; $display("FAIL release_count got=%0d want=2", bus.o_count); end
        step();
        #1;
        total++; if (bus.o_retire_valid !== 1'b0) begin bad++; $display("FAIL release_drained got=%0b want=0", bus.o_retire_valid); end
    endtask

    task automatic test_flush();
        bus.i_retire_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.i_alloc_valid = 1'b1;
            bus.i_alloc_tag   = 32'h40 + 32'(i);
            #1;
            total++; if (bus.o_alloc_id !== 3'(i)) begin bad++; $display("FAIL pre_flush_alloc_id[%0d] got=%0d want=%0d", i, bus.o_alloc_id, i); end
            step();
        end
        bus.i_alloc_valid = 1'b0;
        drive_fill(3'd6, 32'hB6);
        step();
        bus.i_fill_valid = 1'b0;
        step();
        #1;
        total++; if (bus.o_count !== 4'd5 || bus.o_retire_valid !== 1'b1 || bus.o_retire_id !== 3'd6)
            begin bad++; $display("FAIL pre_flush_state got=%0d/%0b/%0d want=5/1/6", bus.o_count, bus.o_retire_valid, bus.o_retire_id); end
        bus.i_flush        = 1'b1;
        bus.i_alloc_valid  = 1'b1;
        bus.i_alloc_tag    = 32'h77;
        bus.i_retire_ready = 1'b1;
        drive_fill(3'd7, 32'h1234);
        #1;
        total++; if (bus.o_buf_clear_tag_valid !== 8'hFF) begin bad++; $display("FAIL flush_clr_tag got=%02h want=ff", bus.o_buf_clear_tag_valid); end
        total++; if (bus.o_buf_clear_data_valid !== 8'hFF) begin bad++; $display("FAIL flush_clr_data got=%02h want=ff", bus.o_buf_clear_data_valid); end
        total++; if (bus.o_buf_set_tag_valid !== 8'h00 || bus.o_buf_set_data_valid !== 8'h00)
            begin bad++; $display("FAIL flush_sets got=%02h/%02h want=00/00", bus.o_buf_set_tag_valid, bus.o_buf_set_data_valid); end
        total++; if (bus.o_buf_write_tag_en !== 1'b0 || bus.o_buf_write_data_en !== 1'b0 || bus.o_alloc_ready !== 1'b0)
            begin bad++; $display("FAIL flush_writes got=%0b/%0b/%0b want=0/0/0", bus.o_buf_write_tag_en, bus.o_buf_write_data_en, bus.o_alloc_ready); end
        step();
        bus.i_flush        = 1'b0;
        bus.i_alloc_valid  = 1'b0;
        bus.i_fill_valid   = 1'b0;
        bus.i_retire_ready = 1'b0;
        #1;
        total++; if (bus.o_count !== 4'd0 || bus.o_empty !== 1'b1 || bus.o_retire_valid !== 1'b0 || bus.o_fill_err !== 1'b0)
            begin bad++; $display("FAIL post_flush got=%0d/%0b/%0b/%0b want=0/1/0/0", bus.o_count, bus.o_empty, bus.o_retire_valid, bus.o_fill_err); end
        bus.i_alloc_valid = 1'b1;
        bus.i_alloc_tag   = 32'h50;
        #1;
        total++; if (bus.o_alloc_id !== 3'd0 || bus.o_buf_set_tag_valid !== 8'h01)
            begin bad++; $display("FAIL post_flush_alloc got=%0d/%02h want=0/01", bus.o_alloc_id, bus.o_buf_set_tag_valid); end
        step();
        bus.i_alloc_valid = 1'b0;
    endtask

    task automatic test_fill_err();
        bus.i_retire_ready = 1'b1;
        drive_fill(3'd5, 32'hDEAD);
        #1;
        total++; if (bus.o_buf_write_data_en !== 1'b0 || bus.o_buf_set_data_valid !== 8'h00)
            begin bad++; $display("FAIL unalloc_fill_write got=%0b/%02h want=0/00", bus.o_buf_write_data_en, bus.o_buf_set_data_valid); end
        step();
        drive_fill(3'd0, 32'hE0);
        #1;
        total++; if (bus.o_fill_err !== 1'b1) begin bad++; $display("FAIL unalloc_fill_err got=%0b want=1", bus.o_fill_err); end
        total++; if (bus.o_buf_write_data_en !== 1'b1 || bus.o_buf_set_data_valid !== 8'h01)
            begin bad++; $display("FAIL legal_fill got=%0b/%02h want=1/01", bus.o_buf_write_data_en, bus.o_buf_set_data_valid); end
        step();
        drive_fill(3'd0, 32'hE1);
        #1;
        total++; if (bus.o_fill_err !== 1'b0) begin bad++; $display("FAIL err_single_pulse got=%0b want=0", bus.o_fill_err); end
        total++; if (bus.o_buf_write_data_en !== 1'b0) begin bad++; $display("FAIL refill_write got=%0b want=0", bus.o_buf_write_data_en); end
        step();
        bus.i_fill_valid = 1'b0;
        #1;
        total++; if (bus.o_fill_err !== 1'b1) begin bad++; $display("FAIL refill_err got=%0b want=1", bus.o_fill_err); end
        total++; if (bus.o_retire_valid !== 1'b1 || bus.o_retire_data !== 32'hE0 || bus.o_retire_tag !== 32'h50)
            begin bad++; $display("FAIL refill_retire got=%0b/%08h/%08h want=1/e0/50", bus.o_retire_valid, bus.o_retire_data, bus.o_retire_tag); end
        step();
        #1;
        total++; if (bus.o_fill_err !== 1'b0) begin bad++; $display("FAIL refill_err_clear got=%0b want=0", bus.o_fill_err); end
        bus.i_alloc_valid = 1'b1;
        bus.i_alloc_tag   = 32'h51;
        drive_fill(3'd1, 32'hF1);
        #1;
        total++; if (bus.o_alloc_id !== 3'd1 || bus.o_buf_write_data_en !== 1'b0)
            begin bad++; $display("FAIL same_cycle_fill got=%0d/%0b want=1/0", bus.o_alloc_id, bus.o_buf_write_data_en); end
        step();
        bus.i_alloc_valid = 1'b0;
        bus.i_fill_valid  = 1'b0;
        #1;
        total++; if (bus.o_fill_err !== 1'b1 || bus.o_count !== 4'd1)
            begin bad++; $display("FAIL same_cycle_err got=%0b/%0d want=1/1", bus.o_fill_err, bus.o_count); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        bus.i_retire_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.i_alloc_valid = 1'b1;
            bus.i_alloc_tag   = 32'h30 + 32'(i);
            step();
        end
        bus.i_alloc_valid = 1'b0;
        drive_fill(3'd0, 32'hC0);
        step();
        bus.i_fill_valid  = 1'b0;
        bus.i_alloc_valid = 1'b1;
        bus.i_alloc_tag   = 32'h99;
        #1;
        total++; if (bus.o_alloc_ready !== 1'b0 || bus.o_full !== 1'b1)
            begin bad++; $display("FAIL wrap_retire_cycle got=%0b/%0b want=0/1", bus.o_alloc_ready, bus.o_full); end
        step();
        #1;
        total++; if (bus.o_alloc_ready !== 1'b1 || bus.o_alloc_id !== 3'd0 || bus.o_count !== 4'd7)
            begin bad++; $display("FAIL wrap_next_cycle got=%0b/%0d/%0d want=1/0/7", bus.o_alloc_ready, bus.o_alloc_id, bus.o_count); end
        total++; if (bus.o_buf_set_tag_valid !== 8'h01 || bus.o_buf_clear_data_valid !== 8'h01)
            begin bad++; $display("FAIL wrap_vectors got=%02h/%02h want=01/01", bus.o_buf_set_tag_valid, bus.o_buf_clear_data_valid); end
        total++; if (bus.o_retire_valid !== 1'b1 || bus.o_retire_tag !== 32'h30 || bus.o_retire_data !== 32'hC0)
            begin bad++; $display("FAIL wrap_retire got=%0b/%08h/%08h want=1/30/c0", bus.o_retire_valid, bus.o_retire_tag, bus.o_retire_data); end
        step();
        bus.i_alloc_valid = 1'b0;
        #1;
        total++; if (bus.o_count !== 4'd8 || bus.o_full !== 1'b1)
            begin bad++; $display("FAIL wrap_refull got=%0d/%0b want=8/1", bus.o_count, bus.o_full); end
    endtask

    initial begin
        test_reset();
        test_alloc_full();
        test_fill_order();
        test_retire_stall();
        test_flush();
        test_fill_err();
        test_full_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end
endmodule
